ddr_burst_sched: RTL and testbench

Sequencing controller between the FIFO pair in the write/read FIFO wrapper and the DDR AXI4 port, all on `ddr_clk`. It watches the write-FIFO read water level and the read-FIFO write water level, then issues single fixed-length AXI4 INCR bursts: writes drain the write FIFO into a DDR ring buffer, and reads refill the read FIFO from it. Sharing between the two directions is round-robin. Ring occupancy tracking prevents overwrite of unread data and prevents reads of unwritten data.

---
 rtl/ddr_sched_pkg.sv | 24 ++
 rtl/ring_ptr_tracker.sv | 44 ++++
 rtl/ddr_burst_sched.sv | 171 +++++++++++++++++
 tb/tb_ddr_burst_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_sched_pkg.sv
// Shared types and constants for the DDR ring-buffer burst scheduler.
package ddr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA
  } state_t;

  localparam int unsigned DATA_W     = 256;
  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned BEAT_BYTES = DATA_W / 8;
  localparam int unsigned LEVEL_W    = 11;
  localparam int unsigned FILL_W     = 17;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ring_ptr_tracker.sv
// DDR ring write/read pointers and committed-beat fill, advanced one burst per commit pulse.
module ring_ptr_tracker
  import ddr_sched_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned RING_BEATS = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_commit,
  input  logic              rd_commit,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [FILL_W-1:0] ring_fill
);

  localparam int unsigned PTR_W = $clog2(RING_BEATS);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Power-of-two ring: natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ring_fill <= '0;
    end else begin
      if (wr_commit) wr_ptr <= wr_ptr + PTR_W'(BURST_LEN);
      if (rd_commit) rd_ptr <= rd_ptr + PTR_W'(BURST_LEN);
      case ({wr_commit, rd_commit})
        2'b10:   ring_fill <= ring_fill + FILL_W'(BURST_LEN);
        2'b01:   ring_fill <= ring_fill - FILL_W'(BURST_LEN);
        default: ring_fill <= ring_fill;
      endcase
    end
  end

  assign wr_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(wr_ptr) * ADDR_W'(BEAT_BYTES);
  assign rd_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_ptr) * ADDR_W'(BEAT_BYTES);

endmodule

// File: rtl/ddr_burst_sched.sv
// Round-robin AXI4 burst scheduler moving the write FIFO into a DDR ring and the ring back out to the read FIFO.
module ddr_burst_sched
  import ddr_sched_pkg::*;
#(
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned RING_BEATS  = 65536,
  parameter int unsigned RFIFO_DEPTH = 1024
) (
  input  logic               ddr_clk,
  input  logic               rstn,
  input  logic [LEVEL_W-1:0] wfifo_rd_water_level,
  input  logic [DATA_W-1:0]  wfifo_rd_data256_in,
  output logic               wfifo_rd_req,
  input  logic [LEVEL_W-1:0] rfifo_wr_water_level,
  output logic               rfifo_wr_req,
  output logic [DATA_W-1:0]  rfifo_wr_data256_out,
  output logic [ADDR_W-1:0]  axi_awaddr,
  output logic [7:0]         axi_awlen,
  output logic               axi_awvalid,
  input  logic               axi_awready,
  output logic [DATA_W-1:0]  axi_wdata,
  output logic [STRB_W-1:0]  axi_wstrb,
  output logic               axi_wlast,
  output logic               axi_wvalid,
  input  logic               axi_wready,
  input  logic [1:0]         axi_bresp,
  input  logic               axi_bvalid,
  output logic               axi_bready,
  output logic [ADDR_W-1:0]  axi_araddr,
  output logic [7:0]         axi_arlen,
  output logic               axi_arvalid,
  input  logic               axi_arready,
  input  logic [DATA_W-1:0]  axi_rdata,
  input  logic               axi_rlast,
  input  logic               axi_rvalid,
  output logic               axi_rready,
  output logic [FILL_W-1:0]  ring_fill,
  output logic               err_resp
);

  localparam int unsigned BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned FILL_X_W  = FILL_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t              state, state_nxt;
  logic                last_dir, last_dir_nxt;
  logic [BEAT_W-1:0]   beat, beat_nxt;
  logic                err_nxt;
  logic                wr_commit, rd_commit;
  logic                wr_ok, rd_ok;
  logic [FILL_X_W-1:0] wr_pend;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic                awvalid_d, wvalid_d, wlast_d, bready_d, arvalid_d, rready_d;

  ring_ptr_tracker #(
    .BURST_LEN (BURST_LEN),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .RING_BEATS(RING_BEATS)
  ) u_ring (
    .clk      (ddr_clk),
    .rst_n    (rstn),
    .wr_commit(wr_commit),
    .rd_commit(rd_commit),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .ring_fill(ring_fill)
  );

  // The in-flight write burst counts against ring space until its response commits it.
  assign wr_pend = (state inside {ST_WR_ADDR, ST_WR_DATA, ST_WR_RESP}) ? FILL_X_W'(BURST_LEN) : '0;
  assign wr_ok   = (32'(wfifo_rd_water_level) >= BURST_LEN) &&
                   ((FILL_X_W'(ring_fill) + wr_pend) <= FILL_X_W'(RING_BEATS - BURST_LEN));
  assign rd_ok   = ((32'(rfifo_wr_water_level) + BURST_LEN) <= RFIFO_DEPTH) &&
                   (32'(ring_fill) >= BURST_LEN);

  always_comb begin
    state_nxt    = state;
    last_dir_nxt = last_dir;
    beat_nxt     = beat;
    err_nxt      = err_resp;
    wr_commit    = 1'b0;
    rd_commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_ok && (!rd_ok || last_dir == DIR_RD)) begin
          state_nxt    = ST_WR_ADDR;
          last_dir_nxt = DIR_WR;
        end else if (rd_ok) begin
          state_nxt    = ST_RD_ADDR;
          last_dir_nxt = DIR_RD;
        end
      end
      ST_WR_ADDR: if (axi_awready) state_nxt = ST_WR_DATA;
      ST_WR_DATA: begin
        if (axi_wvalid && axi_wready) begin
          if (beat == LAST_BEAT) begin
            beat_nxt  = '0;
            state_nxt = ST_WR_RESP;
          end else begin
            beat_nxt = beat + BEAT_W'(1);
          end
        end
      end
      ST_WR_RESP: begin
        if (axi_bvalid) begin
          wr_commit = 1'b1;
          if (axi_bresp != RESP_OKAY) err_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_ADDR: if (axi_arready) state_nxt = ST_RD_DATA;
      ST_RD_DATA: begin
        if (axi_rvalid && axi_rlast) begin
          rd_commit = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    awvalid_d = (state_nxt == ST_WR_ADDR);
    wvalid_d  = (state_nxt == ST_WR_DATA);
    wlast_d   = (state_nxt == ST_WR_DATA) && (beat_nxt == LAST_BEAT);
    bready_d  = (state_nxt == ST_WR_RESP);
    arvalid_d = (state_nxt == ST_RD_ADDR);
    rready_d  = (state_nxt == ST_RD_DATA);
  end

  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      last_dir    <= DIR_RD;
      beat        <= '0;
      err_resp    <= 1'b0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_wlast   <= 1'b0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      axi_awaddr  <= '0;
      axi_araddr  <= '0;
    end else begin
      state       <= state_nxt;
      last_dir    <= last_dir_nxt;
      beat        <= beat_nxt;
      err_resp    <= err_nxt;
      axi_awvalid <= awvalid_d;
      axi_wvalid  <= wvalid_d;
      axi_wlast   <= wlast_d;
      axi_bready  <= bready_d;
      axi_arvalid <= arvalid_d;
      axi_rready  <= rready_d;
      axi_awaddr  <= wr_addr;
      axi_araddr  <= rd_addr;
    end
  end

  // Pointers only move on commit, so the registered addresses are stable through each address phase.
  assign axi_awlen            = 8'(BURST_LEN - 1);
  assign axi_arlen            = 8'(BURST_LEN - 1);
  assign axi_wstrb            = '1;
  assign axi_wdata            = wfifo_rd_data256_in;
  assign wfifo_rd_req         = axi_wvalid & axi_wready;
  assign rfifo_wr_req         = axi_rvalid & axi_rready;
  assign rfifo_wr_data256_out = axi_rdata;

endmodule

// File: tb/tb_ddr_burst_sched.sv
// Directed bench: a step table of eligibility scenarios against an AXI ring-memory slave, plus timing and reset sequences.
module tb_ddr_burst_sched;

  localparam int unsigned BURST_LEN   = 16;
  localparam int unsigned ADDR_W      = 28;
  localparam int unsigned BASE_ADDR   = 32'h2000;
  localparam int unsigned RING_BEATS  = 64;
  localparam int unsigned RFIFO_DEPTH = 1024;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam int NSTEP = 17;

  logic               clk, rstn;
  logic [10:0]        wlvl, rlvl;
  logic [255:0]       wfifo_data;
  logic               wfifo_rd_req, rfifo_wr_req;
  logic [255:0]       rfifo_wr_data256_out;
  logic [ADDR_W-1:0]  axi_awaddr, axi_araddr;
  logic [7:0]         axi_awlen, axi_arlen;
  logic               axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic [255:0]       axi_wdata, axi_rdata;
  logic [31:0]        axi_wstrb;
  logic [1:0]         axi_bresp;
  logic               axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic               axi_rlast, axi_rvalid, axi_rready;
  logic [16:0]        ring_fill;
  logic               err_resp;

  ddr_burst_sched #(
    .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR),
    .RING_BEATS(RING_BEATS), .RFIFO_DEPTH(RFIFO_DEPTH)
  ) dut (
    .ddr_clk(clk), .rstn(rstn),
    .wfifo_rd_water_level(wlvl), .wfifo_rd_data256_in(wfifo_data), .wfifo_rd_req(wfifo_rd_req),
    .rfifo_wr_water_level(rlvl), .rfifo_wr_req(rfifo_wr_req), .rfifo_wr_data256_out(rfifo_wr_data256_out),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .ring_fill(ring_fill), .err_resp(err_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Slave / FIFO model state shared with the step driver
  logic         tog = 1'b0;
  logic [1:0]   bresp_cfg = 2'b00;
  logic [31:0]  head = 32'd1;
  logic [31:0]  rd_exp = 32'd1;
  logic [255:0] mem [0:63];
  bit           pop_q = 0, b_pending = 0, rd_active = 0;
  bit           prev_aw_wait = 0, prev_w_wait = 0;
  logic [ADDR_W-1:0] prev_awaddr = '0;
  int cyc = 0, w_beats = 0, r_beats = 0, wr_idx = 0, rd_idx = 0;
  int aw_cnt = 0, ar_cnt = 0, done_cnt = 0, pops = 0, pushes = 0, wlast_cnt = 0;
  int aw_cyc_last = 0, aw_cyc_prev = 0;
  logic [ADDR_W-1:0] aw_addr_rec = '0, ar_addr_rec = '0;
  logic [7:0] aw_len_rec = '0, ar_len_rec = '0;

  // AXI slave backed by a 64-beat ring memory; inputs change on negedge, handshakes sampled just after
  initial begin : slave
    forever begin
      @(negedge clk);
      if (pop_q) head = head + 32'd1;
      pop_q       = 0;
      axi_awready = tog ? cyc[0] : 1'b1;
      axi_wready  = tog ? ~cyc[0] : 1'b1;
      axi_arready = tog ? cyc[0] : 1'b1;
      axi_bvalid  = b_pending;
      axi_bresp   = bresp_cfg;
      if (rd_active && (!tog || cyc[0])) begin
        axi_rvalid = 1'b1;
        axi_rdata  = mem[(rd_idx + r_beats) % 64];
        axi_rlast  = (r_beats == 15);
      end else begin
        axi_rvalid = 1'b0;
        axi_rdata  = '0;
        axi_rlast  = 1'b0;
      end
      wfifo_data = {8{head}};
      #1;
      if (prev_aw_wait) begin
        chk("awvalid_hold", axi_awvalid, 1);
        chk("awaddr_hold", axi_awaddr, prev_awaddr);
      end
      prev_aw_wait = axi_awvalid && !axi_awready;
      prev_awaddr  = axi_awaddr;
      if (axi_awvalid && axi_awready) begin
        aw_cnt++;
        aw_addr_rec = axi_awaddr;
        aw_len_rec  = axi_awlen;
        aw_cyc_prev = aw_cyc_last;
        aw_cyc_last = cyc;
        wr_idx      = (int'(axi_awaddr - BASE_A) / 32) % 64;
        w_beats     = 0;
      end
      if (prev_w_wait) chk("wvalid_hold", axi_wvalid, 1);
      prev_w_wait = axi_wvalid && !axi_wready;
      chk("wfifo_rd_req", wfifo_rd_req, axi_wvalid & axi_wready);
      if (wfifo_rd_req) pops++;
      if (axi_wvalid) begin
        chk("wlast_pos", axi_wlast, (w_beats == 15));
        if (axi_wready) begin
          mem[(wr_idx + w_beats) % 64] = axi_wdata;
          w_beats++;
          pop_q = 1;
          if (axi_wlast) wlast_cnt++;
          if (w_beats == 16) b_pending = 1;
        end
      end
      if (axi_bvalid) begin
        chk("bready", axi_bready, 1);
        if (axi_bready) begin
          b_pending = 0;
          done_cnt++;
        end
      end
      if (axi_arvalid && axi_arready) begin
        ar_cnt++;
        ar_addr_rec = axi_araddr;
        ar_len_rec  = axi_arlen;
        rd_idx      = (int'(axi_araddr - BASE_A) / 32) % 64;
        r_beats     = 0;
        rd_active   = 1;
      end
      chk("rfifo_wr_req", rfifo_wr_req, axi_rvalid & axi_rready);
      if (axi_rvalid) begin
        chk("rready", axi_rready, 1);
        if (axi_rready) begin
          checks++;
          if (rfifo_wr_data256_out !== {8{rd_exp}}) begin
            errors++;
            $display("FAIL rfifo_data: got 0x%0h expected 0x%0h", rfifo_wr_data256_out[31:0], rd_exp);
          end
          rd_exp = rd_exp + 32'd1;
          pushes++;
          r_beats++;
          if (r_beats == 16) begin
            rd_active = 0;
            done_cnt++;
          end
        end
      end
      cyc++;
    end
  end

  typedef struct {
    int          wlvl;
    int          rlvl;
    logic        tog;
    logic [1:0]  bresp;
    int          dir;      // 0 none, 1 write, 2 read
    logic [27:0] addr;
    int          fill;
    logic        err;
  } step_t;

  step_t steps [NSTEP];

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  initial begin : main
    int got;
    int aw0, ar0, d0;
    steps[0]  = '{16, 1024, 1'b0, 2'b00, 1, 28'h2000, 16, 1'b0};
    steps[1]  = '{16, 1024, 1'b0, 2'b00, 1, 28'h2200, 32, 1'b0};
    steps[2]  = '{0,  0,    1'b0, 2'b00, 2, 28'h2000, 16, 1'b0};
    steps[3]  = '{16, 0,    1'b0, 2'b00, 1, 28'h2400, 32, 1'b0};
    steps[4]  = '{16, 0,    1'b0, 2'b00, 2, 28'h2200, 16, 1'b0};
    steps[5]  = '{16, 0,    1'b0, 2'b00, 1, 28'h2600, 32, 1'b0};
    steps[6]  = '{16, 0,    1'b0, 2'b00, 2, 28'h2400, 16, 1'b0};
    steps[7]  = '{16, 1024, 1'b1, 2'b10, 1, 28'h2000, 32, 1'b1};
    steps[8]  = '{16, 1024, 1'b0, 2'b00, 1, 28'h2200, 48, 1'b1};
    steps[9]  = '{16, 1024, 1'b0, 2'b00, 1, 28'h2400, 64, 1'b1};
    steps[10] = '{16, 1024, 1'b0, 2'b00, 0, 28'h0,    64, 1'b1};
    steps[11] = '{0,  0,    1'b0, 2'b00, 2, 28'h2600, 48, 1'b1};
    steps[12] = '{16, 1024, 1'b0, 2'b00, 1, 28'h2600, 64, 1'b1};
    steps[13] = '{16, 0,    1'b0, 2'b00, 2, 28'h2000, 48, 1'b1};
    steps[14] = '{15, 1024, 1'b0, 2'b00, 0, 28'h0,    48, 1'b1};
    steps[15] = '{0,  1009, 1'b0, 2'b00, 0, 28'h0,    48, 1'b1};
    steps[16] = '{0,  1008, 1'b1, 2'b00, 2, 28'h2200, 32, 1'b1};

    rstn = 1'b0;
    wlvl = '0;
    rlvl = 11'(RFIFO_DEPTH);
    repeat (3) tick();
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_wlast", axi_wlast, 0);
    chk("rst_bready", axi_bready, 0);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_awaddr", axi_awaddr, 0);
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_awlen", axi_awlen, 15);
    chk("rst_arlen", axi_arlen, 15);
    chk("rst_fill", ring_fill, 0);
    chk("rst_err", err_resp, 0);
    chk("wstrb", axi_wstrb, 32'hFFFF_FFFF);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) tick();
    chk("idle_no_aw", axi_awvalid | axi_arvalid, 0);

    for (int s = 0; s < NSTEP; s++) begin
      @(negedge clk);
      wlvl = 11'(steps[s].wlvl);
      rlvl = 11'(steps[s].rlvl);
      tog = steps[s].tog;
      bresp_cfg = steps[s].bresp;
      aw0 = aw_cnt; ar0 = ar_cnt; d0 = done_cnt;
      pops = 0; pushes = 0; wlast_cnt = 0;
      got = 0;
      for (int i = 0; i < 40 && got == 0; i++) begin
        tick();
        if (aw_cnt != aw0) got = 1;
        else if (ar_cnt != ar0) got = 2;
      end
      wlvl = '0;
      rlvl = 11'(RFIFO_DEPTH);
      chk($sformatf("step%0d_dir", s), got, steps[s].dir);
      if (got == 1) begin
        chk($sformatf("step%0d_awaddr", s), aw_addr_rec, steps[s].addr);
        chk($sformatf("step%0d_awlen", s), aw_len_rec, 15);
      end else if (got == 2) begin
        chk($sformatf("step%0d_araddr", s), ar_addr_rec, steps[s].addr);
        chk($sformatf("step%0d_arlen", s), ar_len_rec, 15);
      end
      if (got != 0) begin
        for (int i = 0; i < 80 && done_cnt == d0; i++) tick();
        chk($sformatf("step%0d_done", s), done_cnt - d0, 1);
      end
      tick();
      tick();
      chk($sformatf("step%0d_fill", s), ring_fill, steps[s].fill);
      chk($sformatf("step%0d_err", s), err_resp, steps[s].err);
      if (got == 1) begin
        chk($sformatf("step%0d_pops", s), pops, 16);
        chk($sformatf("step%0d_wlast_cnt", s), wlast_cnt, 1);
      end else if (got == 2) begin
        chk($sformatf("step%0d_pushes", s), pushes, 16);
      end
    end

    // Back-to-back zero-wait writes: BURST_LEN+3 cycles apart, stopping when the ring is full
    @(negedge clk);
    tog = 1'b0;
    bresp_cfg = 2'b00;
    aw0 = aw_cnt;
    wlvl = 11'd16;
    rlvl = 11'(RFIFO_DEPTH);
    for (int i = 0; i < 80 && aw_cnt < aw0 + 2; i++) tick();
    chk("b2b_two_aw", aw_cnt - aw0, 2);
    chk("b2b_spacing", aw_cyc_last - aw_cyc_prev, BURST_LEN + 3);
    chk("b2b_awaddr", aw_addr_rec, 28'h2200);
    repeat (40) tick();
    chk("b2b_stop_full", aw_cnt - aw0, 2);
    chk("b2b_fill", ring_fill, 64);
    chk("b2b_err_sticky", err_resp, 1);
    wlvl = '0;

    // Asynchronous reset between clock edges
    @(negedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("async_rst_err", err_resp, 0);
    chk("async_rst_fill", ring_fill, 0);
    chk("async_rst_awaddr", axi_awaddr, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
